// File: rtl/axis_frame_arb_mux.sv
// axis_frame_arb_mux
// Frame-atomic round-robin arbiter that multiplexes S_COUNT AXI-Stream inputs
// onto one output through a 2-entry skid buffer.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   s_axis_t{data,keep,user}      packed per-stream payload, stream i at [i*W +: W]
//   s_axis_t{valid,ready,last}    per-stream handshake and end of frame
//   m_axis_t{data,keep,user,last} muxed output payload
//   m_axis_t{valid,ready}         output handshake
//   m_axis_tid                    source index tag (0 unless tagging is enabled)
//   grant_index                   currently / most recently granted input
//   grant_active                  high while a frame is in progress
//
// Optional feature: define AXIS_FRAME_ARB_MUX_TID_TAG_EN to tag every output
// beat with its source input index on m_axis_tid.

module axis_frame_arb_mux #(
  parameter int unsigned S_COUNT    = 4,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned KEEP_WIDTH = (DATA_WIDTH + 7) / 8,
  parameter int unsigned USER_WIDTH = 1,
  parameter int unsigned ID_WIDTH   = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [S_COUNT*DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [S_COUNT*KEEP_WIDTH-1:0]   s_axis_tkeep,
  input  logic [S_COUNT-1:0]              s_axis_tvalid,
  output logic [S_COUNT-1:0]              s_axis_tready,
  input  logic [S_COUNT-1:0]              s_axis_tlast,
  input  logic [S_COUNT*USER_WIDTH-1:0]   s_axis_tuser,
  output logic [DATA_WIDTH-1:0]           m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]           m_axis_tkeep,
  output logic [USER_WIDTH-1:0]           m_axis_tuser,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast,
  output logic [ID_WIDTH-1:0]             m_axis_tid,
  output logic [ID_WIDTH-1:0]             grant_index,
  output logic                            grant_active
);

  localparam int unsigned GW = (S_COUNT > 1) ? $clog2(S_COUNT) : 1;

  typedef enum logic {IDLE, ACTIVE} state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [KEEP_WIDTH-1:0] keep;
    logic [USER_WIDTH-1:0] user;
    logic                  last;
  } beat_t;

  state_t          state;
  logic [GW-1:0]   grant;
  logic [GW-1:0]   last_grant;
  logic [GW-1:0]   rr_pick;
  logic [GW-1:0]   rr_cand;
  logic            rr_found;

  beat_t           sel_beat;
  logic            accept;

  beat_t           out_beat;
  logic            out_valid;
  beat_t           skid_beat;
  logic            skid_valid;

`ifdef AXIS_FRAME_ARB_MUX_TID_TAG_EN
  logic [ID_WIDTH-1:0] out_tid;
  logic [ID_WIDTH-1:0] skid_tid;
`endif

  // Round-robin search starting one past the last granted input, with wrap.
  always_comb begin
    rr_found = 1'b0;
    rr_pick  = last_grant;
    rr_cand  = last_grant;
    for (int unsigned k = 0; k < S_COUNT; k++) begin
      rr_cand = (rr_cand == GW'(S_COUNT - 1)) ? '0 : rr_cand + GW'(1);
      if (!rr_found && s_axis_tvalid[rr_cand]) begin
        rr_found = 1'b1;
        rr_pick  = rr_cand;
      end
    end
  end

  // Payload of the granted input.
  always_comb begin
    sel_beat.data = s_axis_tdata[32'(grant) * DATA_WIDTH +: DATA_WIDTH];
    sel_beat.keep = s_axis_tkeep[32'(grant) * KEEP_WIDTH +: KEEP_WIDTH];
    sel_beat.user = s_axis_tuser[32'(grant) * USER_WIDTH +: USER_WIDTH];
    sel_beat.last = s_axis_tlast[grant];
  end

  // Ready depends only on registered state, so m_axis_tready never reaches
  // the inputs combinationally; the skid entry absorbs the in-flight beat.
  always_comb begin
    s_axis_tready = '0;
    if (state == ACTIVE && !skid_valid) begin
      s_axis_tready[grant] = 1'b1;
    end
  end

  assign accept = (state == ACTIVE) && !skid_valid && s_axis_tvalid[grant];

  // Arbitration FSM and 2-entry output skid buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      grant        <= '0;
      last_grant   <= GW'(S_COUNT - 1);
      grant_active <= 1'b0;
      out_beat     <= '0;
      out_valid    <= 1'b0;
      skid_beat    <= '0;
      skid_valid   <= 1'b0;
`ifdef AXIS_FRAME_ARB_MUX_TID_TAG_EN
      out_tid      <= '0;
      skid_tid     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (rr_found) begin
            grant        <= rr_pick;
            state        <= ACTIVE;
            grant_active <= 1'b1;
          end
        end
        ACTIVE: begin
          // Grant is held until the tlast beat is taken, whatever else requests.
          if (accept && sel_beat.last) begin
            state        <= IDLE;
            last_grant   <= grant;
            grant_active <= 1'b0;
          end
        end
      endcase

      if (m_axis_tready || !out_valid) begin
        if (skid_valid) begin
          out_beat   <= skid_beat;
          out_valid  <= 1'b1;
          skid_valid <= 1'b0;
`ifdef AXIS_FRAME_ARB_MUX_TID_TAG_EN
          out_tid    <= skid_tid;
`endif
        end else begin
          out_valid <= accept;
          if (accept) begin
            out_beat <= sel_beat;
`ifdef AXIS_FRAME_ARB_MUX_TID_TAG_EN
            out_tid  <= ID_WIDTH'(grant);
`endif
          end
        end
      end else if (accept) begin
        skid_beat  <= sel_beat;
        skid_valid <= 1'b1;
`ifdef AXIS_FRAME_ARB_MUX_TID_TAG_EN
        skid_tid   <= ID_WIDTH'(grant);
`endif
      end
    end
  end

  assign m_axis_tdata  = out_beat.data;
  assign m_axis_tkeep  = out_beat.keep;
  assign m_axis_tuser  = out_beat.user;
  assign m_axis_tlast  = out_beat.last;
  assign m_axis_tvalid = out_valid;
  assign grant_index   = ID_WIDTH'(grant);

`ifdef AXIS_FRAME_ARB_MUX_TID_TAG_EN
  assign m_axis_tid = out_tid;
`else
  assign m_axis_tid = '0;
`endif

endmodule

// File: doc/axis_frame_arb_mux.md
AXIS_FRAME_ARB_MUX -- requirements
Module: axis_frame_arb_mux

Interface
REQ-001 S_COUNT, 4, number of AXI-Stream inputs sharing one output (2..16).
REQ-002 DATA_WIDTH, 64, tdata width per stream.
REQ-003 KEEP_WIDTH, (DATA_WIDTH+7)/8, tkeep width per stream.
REQ-004 USER_WIDTH, 1, tuser width per stream.
REQ-005 ID_WIDTH, 4, m_axis_tid width; SHALL be >= $clog2(S_COUNT).
REQ-006 clk  in  1  single clock for all logic.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 s_axis_tdata  in  S_COUNT*DATA_WIDTH  packed inputs, stream i at [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 s_axis_tkeep  in  S_COUNT*KEEP_WIDTH  packed the same way.
REQ-010 s_axis_tvalid / s_axis_tready / s_axis_tlast  in/out/in  S_COUNT  per-stream handshake and end of frame.
REQ-011 s_axis_tuser  in  S_COUNT*USER_WIDTH  packed per-stream sideband.
REQ-012 m_axis_tdata / m_axis_tkeep / m_axis_tuser  out  DATA_WIDTH / KEEP_WIDTH / USER_WIDTH  muxed output.
REQ-013 m_axis_tvalid / m_axis_tready / m_axis_tlast  out/in/out  1  output handshake.
REQ-014 m_axis_tid  out  ID_WIDTH  source tag (see Configuration).
REQ-015 grant_index  out  ID_WIDTH  index of the currently or most recently granted input.
REQ-016 grant_active  out  1  high while a frame is in progress (state ACTIVE).

Function
REQ-017 FSM SHALL have two states: IDLE and ACTIVE.
REQ-018 IDLE: if any s_axis_tvalid is high, SHALL register the grant round-robin, searching from (last_grant+1) mod S_COUNT upward with wrap, and enter ACTIVE next cycle. All s_axis_tready SHALL be low in IDLE.
REQ-019 ACTIVE: s_axis_tready[grant] SHALL equal the output stage not-full; every other s_axis_tready SHALL be low.
REQ-020 A beat is accepted when tvalid && tready on the granted input. Acceptance of a beat with tlast=1 SHALL return the FSM to IDLE next cycle and update last_grant.
REQ-021 Grants SHALL be frame-atomic: no switch before tlast, regardless of other requests.
REQ-022 Deasserting tvalid on the granted input mid-frame SHALL hold the grant; the output shows no bubble data.
REQ-023 Output stage SHALL be a 2-entry skid buffer: first beat visible on m_axis_* 1 cycle after acceptance; m_axis_tready is not combinationally routed to any s_axis_tready.
REQ-024 Sustained throughput within a frame SHALL be 1 beat/cycle with m_axis_tready high. Exactly one IDLE arbitration cycle SHALL separate consecutive frames.
REQ-025 m_axis_* SHALL hold stable while m_axis_tvalid && !m_axis_tready.
REQ-026 A single-beat frame (tlast on the first beat) SHALL be legal and handled identically.
REQ-027 With all S_COUNT inputs continuously requesting, the grant order SHALL be 0,1,...,S_COUNT-1,0,...

Reset
REQ-028 When rst is high at a clk edge, the block SHALL enter: FSM=IDLE, last_grant=S_COUNT-1 (input 0 wins first), grant_index=0, grant_active=0, skid buffer empty, m_axis_tvalid=0, all s_axis_tready=0, and all other outputs 0.
REQ-029 Reset mid-frame SHALL discard buffered beats; no tlast is emitted for the truncated frame.

Configuration
REQ-030 Macro AXIS_FRAME_ARB_MUX_TID_TAG_EN: when defined, m_axis_tid SHALL carry the source input index, zero-extended, on every beat of the frame.
REQ-031 Without the macro, m_axis_tid SHALL be constant 0 and no tid storage SHALL exist in the skid buffer.

Verification
REQ-032 After reset, inputs 0 and 2 each present a 3-beat frame -> output carries frame 0 then frame 2; one idle cycle between them; grant_index goes 0 then 2.
REQ-033 S_COUNT=4, all inputs continuously request 1-beat frames -> output source order is 0,1,2,3,0,1; m_axis_tid matches with the macro on and is 0 with it off.
REQ-034 Input 1 has a frame in progress while input 0 requests -> input 0 is not granted until input 1's tlast beat is accepted.
REQ-035 m_axis_tready is low for 5 cycles mid-frame -> no beats are lost or duplicated, output is stable while stalled, and the granted s_axis_tready drops within 2 cycles.
REQ-036 rst is asserted on the 2nd beat of a 4-beat frame -> next cycle m_axis_tvalid=0; after release, input 0 is granted first.
